// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM generator: counter width function and
// elaboration-check messages.
package pwm_pkg;

    localparam string MSG_PERIOD = "pwm: PERIOD must be >= 1";
    localparam string MSG_DUTY_HI = "pwm: DUTY must not exceed PERIOD";
    localparam string MSG_DUTY_LO = "pwm: DUTY must not be negative";

    // Counter width for a modulo-PERIOD counter, never narrower than one bit.
    function automatic int calc_cw(input int period);
        int w;
        w = $clog2(period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Free-running modulo-PERIOD counter; wrap flags the terminal count.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [calc_cw(PERIOD)-1:0]   cnt,
    output logic                         wrap
);

    localparam int CW = calc_cw(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_reg;

    assign cnt  = cnt_reg;
    assign wrap = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (wrap) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/pwm.sv
// Fixed-configuration PWM generator: signal is high DUTY of every PERIOD cycles.
// Optional macro PWM_SYNC_OUT_EN adds a registered period_start pulse output.
module pwm
    import pwm_pkg::*;
#(
    parameter int DUTY   = 50,
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
`ifdef PWM_SYNC_OUT_EN
    output logic period_start,
`endif
    output logic signal
);

    localparam int CW = calc_cw(PERIOD);
    // One extra bit so DUTY == PERIOD still compares correctly.
    localparam logic [CW:0] DUTY_W = (CW + 1)'(DUTY);

    if (PERIOD < 1) begin : g_chk_period
        $fatal(1, "%s", MSG_PERIOD);
    end
    if (DUTY > PERIOD) begin : g_chk_duty_hi
        $fatal(1, "%s", MSG_DUTY_HI);
    end
    if (DUTY < 0) begin : g_chk_duty_lo
        $fatal(1, "%s", MSG_DUTY_LO);
    end

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          signal_reg;

    pwm_counter #(
        .PERIOD (PERIOD)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            signal_reg <= 1'b0;
        end else begin
            signal_reg <= ({1'b0, cnt} < DUTY_W);
        end
    end

    assign signal = signal_reg;

`ifdef PWM_SYNC_OUT_EN
    logic period_start_reg;

    // Registered alongside signal_reg so the pulse lines up with the period's first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= (cnt == '0);
        end
    end

    assign period_start = period_start_reg;
    logic unused_wrap;
    assign unused_wrap = wrap;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm: several parameterisations share one clock, expected
// levels are queued per edge and a monitor pops and compares them.
module tb_pwm;

    localparam int ND = 8;
    localparam int DUTY_T   [ND] = '{75,  9, 1,  0, 10,  52, 1, 0};
    localparam int PERIOD_T [ND] = '{100, 10, 6, 10, 10, 104, 1, 1};
    localparam int MID_IDX = 5;
    localparam int RUN_CYCLES = 2100;

    logic          clk;
    logic          rst;
    logic          rst_mid;
    logic [ND-1:0] rst_vec;
    logic [ND-1:0] sig;
    logic          ps;

    int n_checks;
    int n_fail;
    bit started;

    // Bit ND carries the expected period_start of the sync instance.
    logic [ND:0] exp_q [$];
    int phase [ND];
    int ps_phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rst_vec = {ND{rst}} | (ND'(rst_mid) << MID_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
`ifdef PWM_SYNC_OUT_EN
            logic ps_unused;
            pwm #(DUTY_T[gi], PERIOD_T[gi]) u_dut (
                .clk          (clk),
                .rst          (rst_vec[gi]),
                .period_start (ps_unused),
                .signal       (sig[gi])
            );
`else
            pwm #(DUTY_T[gi], PERIOD_T[gi]) u_dut (
                .clk    (clk),
                .rst    (rst_vec[gi]),
                .signal (sig[gi])
            );
`endif
        end
    endgenerate

`ifdef PWM_SYNC_OUT_EN
    logic sig_sync;
    pwm #(5, 20) u_sync (
        .clk          (clk),
        .rst          (rst),
        .period_start (ps),
        .signal       (sig_sync)
    );
`else
    assign ps = 1'b0;
`endif

    // Expected-value producer: one entry per clock edge once reset has been seen.
    always @(posedge clk) begin
        logic [ND:0] e;
        if (rst) started = 1'b1;
        if (started) begin
            for (int i = 0; i < ND; i++) begin
                if (rst_vec[i]) begin
                    e[i] = 1'b0;
                    phase[i] = 0;
                end else begin
                    e[i] = ((phase[i] % PERIOD_T[i]) < DUTY_T[i]);
                    phase[i] = phase[i] + 1;
                end
            end
            if (rst) begin
                e[ND] = 1'b0;
                ps_phase = 0;
            end else begin
                e[ND] = ((ps_phase % 20) == 0);
                ps_phase = ps_phase + 1;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: samples 1 time unit after the edge and checks against the queue.
    always @(posedge clk) begin
        logic [ND:0] e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < ND; i++) begin
                n_checks++;
                if (sig[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL signal_d%0d_p%0d t=%0t got %b expected %b",
                             DUTY_T[i], PERIOD_T[i], $time, sig[i], e[i]);
                end
            end
`ifdef PWM_SYNC_OUT_EN
            n_checks++;
            if (ps !== e[ND]) begin
                n_fail++;
                $display("FAIL period_start t=%0t got %b expected %b", $time, ps, e[ND]);
            end
            n_checks++;
            if (sig_sync !== ((ps_phase - 1) % 20 < 5 && !rst)) begin
                n_fail++;
                $display("FAIL sync_signal t=%0t got %b", $time, sig_sync);
            end
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        started  = 1'b0;
        ps_phase = 0;
        for (int i = 0; i < ND; i++) phase[i] = 0;
        rst     = 1'b1;
        rst_mid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset released at t=%0t", $time);
        // 134 post-reset edges put the 52/104 counter at 30 when rst_mid is sampled.
        repeat (134) @(negedge clk);
        rst_mid = 1'b1;
        $display("mid-period reset asserted at t=%0t", $time);
        repeat (2) @(negedge clk);
        rst_mid = 1'b0;
        $display("mid-period reset released at t=%0t", $time);
        repeat (RUN_CYCLES) @(negedge clk);
        @(negedge clk);
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count got %0d expected at least 12", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
